button_press_conditioner: RTL and testbench
===========================================

Name: button_press_conditioner

Overview:
- Input-side companion to the team's button/LED FSM.
- Takes a raw, asynchronous, bouncy push-button level and synchronises and debounces it.
- Classifies each press as short or long and drives an LED from those classified events.
- Sits between the board button pin and any FSM that consumes clean, single-cycle press events.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples needed before btn_clean changes.
- LONG_CYCLES, 16: cycles btn_clean must stay high, measured from press_pulse, before a press counts as long.
- CNT_W, 8: width of the debounce and hold counters. Must hold max(DEBOUNCE_CYCLES, LONG_CYCLES).

Ports:
- clk, input, 1: single system clock; all logic is on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- button, input, 1: raw button level, asynchronous to clk, may bounce.
- btn_clean, output, 1: debounced button level.
- press_pulse, output, 1: one-cycle pulse on each debounced press.
- release_pulse, output, 1: one-cycle pulse on each debounced release.
- short_press, output, 1: one-cycle pulse when a press releases before becoming long.
- long_press, output, 1: one-cycle pulse when a held press reaches LONG_CYCLES.
- led, output, 1: LED drive; toggled by short presses, cleared by long presses.

Behaviour:
- Reset: synchronous and active-high. On any clk edge with reset=1, all of the following return to 0 on that edge: both synchroniser flops, both counters, the FSM (to IDLE), and every output.
- Synchroniser: two flops, button -> s1 -> s2. Only s2 is used downstream.
- Debounce: a counter increments on each cycle where s2 != btn_clean.
  - Any cycle where s2 == btn_clean clears the counter.
  - When the counter would reach DEBOUNCE_CYCLES, btn_clean takes the value of s2 and the counter clears.
  - Latency: for a clean step on button, btn_clean changes exactly 2+DEBOUNCE_CYCLES edges after the first edge that samples the new level. This is 6 edges with defaults.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no btn_clean change and no pulses.
- Press FSM, registered, states IDLE, PRESSED, LONG:
  - IDLE: on the edge where btn_clean goes 0->1, move to PRESSED, clear the hold counter, and assert press_pulse for that one cycle. press_pulse is coincident with the first btn_clean=1 cycle.
  - PRESSED: the hold counter increments each cycle. If btn_clean goes 1->0 first, move to IDLE and assert release_pulse and short_press in the same cycle. When the hold count reaches LONG_CYCLES, move to LONG and pulse long_press. That is the LONG_CYCLES-th edge after the press_pulse cycle, i.e. long_press goes high exactly LONG_CYCLES cycles after press_pulse.
  - LONG: the hold counter is frozen. On btn_clean 1->0, move to IDLE and pulse release_pulse only; no short_press.
  - Release landing on the same edge the hold count reaches LONG_CYCLES: long wins. long_press pulses and the FSM goes to LONG. release_pulse follows on the next edge; no short_press.
- LED: registered.
  - Toggles on the edge after short_press is high.
  - Forced to 0 on the edge after long_press is high.
  - Otherwise holds its value.
- Pulses: all pulse outputs are registered, exactly one cycle wide, and never re-asserted without a new debounced transition.
- Reset mid-operation: outputs clear with no release_pulse emitted. If button is still held after reset deasserts, a fresh press is detected after the normal 2+DEBOUNCE_CYCLES latency.
- Counter widths: counters saturate, never wrap. The hold counter stops at LONG_CYCLES.

Test Plan:
- Reset: hold reset for 2 edges with button=1 -> btn_clean, all pulses and led are 0 throughout. After release with button still 1, btn_clean=1 and press_pulse=1 on edge 6 after reset deasserts.
- Glitch rejection: button=1 for 3 cycles, then 0 -> btn_clean stays 0; press_pulse, release_pulse and short_press never assert; led stays 0.
- Bounce: button toggles 1,0,1,0,1, one cycle each, then stays 1 -> exactly one press_pulse; btn_clean rises 6 edges after the final 0->1.
- Short press toggles: two presses, each held 10 cycles with a 20-cycle gap -> each gives one press_pulse, then release_pulse and short_press in the same cycle. led goes 0->1 after the first press and 1->0 after the second. long_press never asserts.
- Long press: with led=1, hold button for 30 cycles -> long_press pulses exactly 16 cycles after press_pulse and led goes to 0. On release, release_pulse=1 and short_press=0.
- Reset mid-press: assert reset for 1 edge while in PRESSED -> all outputs are 0 on that edge with no release_pulse. With button held, press_pulse reappears 6 edges later.

Source files
------------

// File: rtl/button_press_conditioner.sv
// -----------------------------------------------------------------------------
// button_press_conditioner
//
// Turns a raw, asynchronous, bouncy push-button level into a clean debounced
// level plus single-cycle press/release/short/long events. It also drives an
// LED that toggles on short presses and clears on long presses.
//
// Ports
//   clk           in   system clock, all logic on the rising edge
//   reset         in   synchronous, active-high reset
//   button        in   raw button level (asynchronous, may bounce)
//   btn_clean     out  debounced button level
//   press_pulse   out  one-cycle pulse on each debounced press
//   release_pulse out  one-cycle pulse on each debounced release
//   short_press   out  one-cycle pulse when a press ends before becoming long
//   long_press    out  one-cycle pulse when a held press reaches LONG_CYCLES
//   led           out  LED drive (toggled by short, cleared by long)
// -----------------------------------------------------------------------------
module button_press_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned LONG_CYCLES     = 16,
   parameter int unsigned CNT_W           = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic button,
   output logic btn_clean,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_press,
   output logic long_press,
   output logic led
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] DB_LIMIT   = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] LONG_LIMIT = CNT_W'(LONG_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   // Synchroniser
   logic r_s1;
   logic r_s2;

   // Debouncer
   logic [CNT_W-1:0] r_db_cnt;
   logic [CNT_W-1:0] w_db_cnt_nxt;
   logic             r_clean;
   logic             w_clean_nxt;

   // Press FSM and registered outputs
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_hold_cnt;
   logic [CNT_W-1:0] w_hold_cnt_nxt;
   logic             r_press,   w_press_nxt;
   logic             r_release, w_release_nxt;
   logic             r_short,   w_short_nxt;
   logic             r_long,    w_long_nxt;
   logic             r_led,     w_led_nxt;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its source; blocking here would collapse
   // the two synchroniser stages into one.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= button;
         r_s2 <= r_s1;
      end
   end

   // Count consecutive cycles where the synchronised level disagrees with
   // btn_clean; adopt the new level on the cycle the run reaches the limit.
   // NOTE: every combinational output gets a default first, so no path
   // through the block leaves a signal unassigned and infers a latch.
   always_comb begin
      w_db_cnt_nxt = '0;
      w_clean_nxt  = r_clean;
      if (r_s2 != r_clean) begin
         if (r_db_cnt + CNT_ONE == DB_LIMIT) begin
            w_clean_nxt = r_s2;
         end else begin
            w_db_cnt_nxt = r_db_cnt + CNT_ONE;
         end
      end
   end

   // The FSM looks at the next debounced level so press_pulse and
   // release_pulse line up with the first cycle of the new btn_clean value.
   always_comb begin
      w_state_nxt    = r_state;
      w_hold_cnt_nxt = r_hold_cnt;
      w_press_nxt    = 1'b0;
      w_release_nxt  = 1'b0;
      w_short_nxt    = 1'b0;
      w_long_nxt     = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_clean_nxt && !r_clean) begin
               w_state_nxt    = PRESSED;
               w_hold_cnt_nxt = '0;
               w_press_nxt    = 1'b1;
            end
         end
         PRESSED: begin
            w_hold_cnt_nxt = r_hold_cnt + CNT_ONE;
            // Reaching the long threshold beats a simultaneous release; the
            // release is then reported from LONG on the following edge.
            if (r_hold_cnt + CNT_ONE == LONG_LIMIT) begin
               w_state_nxt = LONG;
               w_long_nxt  = 1'b1;
            end else if (!w_clean_nxt) begin
               w_state_nxt   = IDLE;
               w_release_nxt = 1'b1;
               w_short_nxt   = 1'b1;
            end
         end
         LONG: begin
            // Level test rather than edge test so a release that coincided
            // with the long threshold is still reported one edge later.
            if (!w_clean_nxt) begin
               w_state_nxt   = IDLE;
               w_release_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // LED reacts to the classified events of the previous cycle.
   always_comb begin
      w_led_nxt = r_led;
      if (r_short) begin
         w_led_nxt = ~r_led;
      end else if (r_long) begin
         w_led_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_db_cnt   <= '0;
         r_clean    <= 1'b0;
         r_state    <= IDLE;
         r_hold_cnt <= '0;
         r_press    <= 1'b0;
         r_release  <= 1'b0;
         r_short    <= 1'b0;
         r_long     <= 1'b0;
         r_led      <= 1'b0;
      end else begin
         r_db_cnt   <= w_db_cnt_nxt;
         r_clean    <= w_clean_nxt;
         r_state    <= w_state_nxt;
         r_hold_cnt <= w_hold_cnt_nxt;
         r_press    <= w_press_nxt;
         r_release  <= w_release_nxt;
         r_short    <= w_short_nxt;
         r_long     <= w_long_nxt;
         r_led      <= w_led_nxt;
      end
   end

   assign btn_clean     = r_clean;
   assign press_pulse   = r_press;
   assign release_pulse = r_release;
   assign short_press   = r_short;
   assign long_press    = r_long;
   assign led           = r_led;

endmodule

// File: tb/tb_button_press_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_press_conditioner
//
// Self-checking bench for button_press_conditioner. An event-level reference
// model (sample history window, press timestamps) predicts every output on
// every edge; scenario tasks add targeted timing checks.
// -----------------------------------------------------------------------------
module tb_button_press_conditioner;

   localparam int DEB = 4;
   localparam int LNG = 16;
   localparam int CW  = 8;

   logic clk = 1'b0;
   logic reset;
   logic button;
   logic btn_clean;
   logic press_pulse;
   logic release_pulse;
   logic short_press;
   logic long_press;
   logic led;

   always #5 clk = ~clk;

   button_press_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .LONG_CYCLES     (LNG),
      .CNT_W           (CW)
   ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .button        (button),
      .btn_clean     (btn_clean),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .short_press   (short_press),
      .long_press    (long_press),
      .led           (led)
   );

   int n_vec = 0;
   int n_err = 0;

   // ---------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------
   bit m_hist[$];        // raw button samples, index 0 = newest edge
   bit m_clean, m_press, m_release, m_short, m_long, m_led;
   bit m_held, m_long_done, m_rel_pending;
   int m_t       = 0;
   int m_press_t = 0;

   logic [5:0] w_obs;
   logic [5:0] w_exp;
   assign w_obs = {btn_clean, press_pulse, release_pulse, short_press, long_press, led};
   assign w_exp = {m_clean, m_press, m_release, m_short, m_long, m_led};

   function automatic void model_edge(input bit b, input bit r);
      bit all_diff;
      bit new_clean;
      bit rise;
      bit fall;
      bit long_now;
      if (r) begin
         m_hist.delete();
         for (int i = 0; i < DEB + 2; i++) m_hist.push_back(1'b0);
         m_clean = 0; m_press = 0; m_release = 0; m_short = 0; m_long = 0;
         m_led = 0; m_held = 0; m_long_done = 0; m_rel_pending = 0;
      end else begin
         m_hist.push_front(b);
         void'(m_hist.pop_back());
         // The debounced level flips once the last DEB samples seen by the
         // debouncer (two edges of synchroniser delay) all disagree with it.
         all_diff = 1'b1;
         for (int i = 2; i < DEB + 2; i++)
            if (m_hist[i] == m_clean) all_diff = 1'b0;
         new_clean = all_diff ? !m_clean : m_clean;
         rise = new_clean && !m_clean;
         fall = !new_clean && m_clean;

         if (m_short)     m_led = !m_led;
         else if (m_long) m_led = 1'b0;

         long_now  = m_held && !m_long_done && (m_t - m_press_t == LNG);
         m_press   = rise;
         m_long    = long_now;
         m_short   = 1'b0;
         m_release = 1'b0;
         if (m_rel_pending) begin
            m_release     = 1'b1;
            m_rel_pending = 1'b0;
            m_held        = 1'b0;
         end
         if (long_now) begin
            m_long_done = 1'b1;
            if (fall) m_rel_pending = 1'b1;
         end else if (fall) begin
            m_release = 1'b1;
            m_short   = !m_long_done;
            m_held    = 1'b0;
         end
         if (rise) begin
            m_held      = 1'b1;
            m_long_done = 1'b0;
            m_press_t   = m_t;
         end
         m_clean = new_clean;
      end
      m_t++;
   endfunction

   // Drive inputs, advance one edge, update the model, sample 1 unit later.
   task automatic tick(input bit b, input bit r);
      button = b;
      reset  = r;
      @(posedge clk);
      model_edge(b, r);
      #1;
   endtask

   task automatic apply_reset();
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
   endtask

   // ---------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------
   task automatic test_reset();
      int press_at = 0;
      for (int i = 0; i < 2; i++) begin
         tick(1'b1, 1'b1);
         n_vec++;
         if (w_obs !== 6'b0) begin
            n_err++;
            $display("FAIL reset_hold edge=%0d got=%b expected=000000", i, w_obs);
         end
      end
      for (int i = 1; i <= 10; i++) begin
         tick(1'b1, 1'b0);
         n_vec++;
         if (w_obs !== w_exp) begin
            n_err++;
            $display("FAIL reset_release edge=%0d got=%b expected=%b", i, w_obs, w_exp);
         end
         if (press_pulse === 1'b1 && press_at == 0) press_at = i;
      end
      n_vec++;
      if (press_at !== 6) begin
         n_err++;
         $display("FAIL reset_press_latency got=%0d expected=6", press_at);
      end
   endtask

   task automatic test_glitch();
      bit seq[$];
      int n_evt = 0;
      apply_reset();
      repeat (3)  seq.push_back(1'b1);
      repeat (12) seq.push_back(1'b0);
      foreach (seq[i]) begin
         tick(seq[i], 1'b0);
         n_vec++;
         if (w_obs !== w_exp) begin
            n_err++;
            $display("FAIL glitch cycle=%0d got=%b expected=%b", i, w_obs, w_exp);
         end
         n_evt += int'(btn_clean) + int'(press_pulse) + int'(release_pulse)
                + int'(short_press) + int'(led);
      end
      n_vec++;
      if (n_evt !== 0) begin
         n_err++;
         $display("FAIL glitch_events got=%0d expected=0", n_evt);
      end
   endtask

   task automatic test_bounce();
      bit seq[$];
      int n_press = 0;
      int rise_at = -1;
      apply_reset();
      seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      repeat (12) seq.push_back(1'b1);
      foreach (seq[i]) begin
         tick(seq[i], 1'b0);
         n_vec++;
         if (w_obs !== w_exp) begin
            n_err++;
            $display("FAIL bounce cycle=%0d got=%b expected=%b", i, w_obs, w_exp);
         end
         n_press += int'(press_pulse);
         if (btn_clean === 1'b1 && rise_at < 0) rise_at = i;
      end
      n_vec++;
      if (n_press !== 1) begin
         n_err++;
         $display("FAIL bounce_press_count got=%0d expected=1", n_press);
      end
      // Final 0->1 sampled at index 4 is edge 1; btn_clean rises on edge 6.
      n_vec++;
      if (rise_at !== 9) begin
         n_err++;
         $display("FAIL bounce_rise_cycle got=%0d expected=9", rise_at);
      end
   endtask

   task automatic test_short_press();
      bit seq[$];
      int n_press = 0, n_short = 0, n_long = 0, n_pair = 0;
      apply_reset();
      repeat (2) begin
         repeat (10) seq.push_back(1'b1);
         repeat (20) seq.push_back(1'b0);
      end
      foreach (seq[i]) begin
         tick(seq[i], 1'b0);
         n_vec++;
         if (w_obs !== w_exp) begin
            n_err++;
            $display("FAIL short cycle=%0d got=%b expected=%b", i, w_obs, w_exp);
         end
         n_press += int'(press_pulse);
         n_short += int'(short_press);
         n_long  += int'(long_press);
         n_pair  += int'(short_press && release_pulse);
         if (i == 29) begin
            n_vec++;
            if (led !== 1'b1) begin
               n_err++;
               $display("FAIL short_led_first got=%b expected=1", led);
            end
         end
      end
      n_vec++;
      if ({n_press, n_short, n_pair, n_long} !== {32'd2, 32'd2, 32'd2, 32'd0}) begin
         n_err++;
         $display("FAIL short_counts got press=%0d short=%0d pair=%0d long=%0d expected 2 2 2 0",
                  n_press, n_short, n_pair, n_long);
      end
      n_vec++;
      if (led !== 1'b0) begin
         n_err++;
         $display("FAIL short_led_second got=%b expected=0", led);
      end
   endtask

   task automatic test_long_press();
      bit seq[$];
      int press_at = -1, long_at = -1, n_rel = 0, n_short = 0;
      apply_reset();
      repeat (10) seq.push_back(1'b1);
      repeat (20) seq.push_back(1'b0);
      repeat (30) seq.push_back(1'b1);
      repeat (20) seq.push_back(1'b0);
      foreach (seq[i]) begin
         tick(seq[i], 1'b0);
         n_vec++;
         if (w_obs !== w_exp) begin
            n_err++;
            $display("FAIL long cycle=%0d got=%b expected=%b", i, w_obs, w_exp);
         end
         if (i == 29) begin
            n_vec++;
            if (led !== 1'b1) begin
               n_err++;
               $display("FAIL long_led_setup got=%b expected=1", led);
            end
         end
         if (i >= 30) begin
            if (press_pulse === 1'b1 && press_at < 0) press_at = i;
            if (long_press === 1'b1 && long_at < 0)   long_at  = i;
            n_rel   += int'(release_pulse);
            n_short += int'(short_press);
         end
      end
      n_vec++;
      if (long_at - press_at !== LNG || press_at < 0) begin
         n_err++;
         $display("FAIL long_latency got=%0d expected=%0d", long_at - press_at, LNG);
      end
      n_vec++;
      if (n_rel !== 1 || n_short !== 0 || led !== 1'b0) begin
         n_err++;
         $display("FAIL long_release got rel=%0d short=%0d led=%b expected 1 0 0",
                  n_rel, n_short, led);
      end
   endtask

   task automatic test_release_on_long();
      bit seq[$];
      int long_at = -1, rel_at = -1, n_short = 0, n_long = 0;
      apply_reset();
      // Held exactly LONG_CYCLES samples: the debounced fall lands on the
      // same edge the hold count reaches the threshold.
      repeat (LNG) seq.push_back(1'b1);
      repeat (25)  seq.push_back(1'b0);
      foreach (seq[i]) begin
         tick(seq[i], 1'b0);
         n_vec++;
         if (w_obs !== w_exp) begin
            n_err++;
            $display("FAIL tie cycle=%0d got=%b expected=%b", i, w_obs, w_exp);
         end
         if (long_press === 1'b1 && long_at < 0)   long_at = i;
         if (release_pulse === 1'b1 && rel_at < 0) rel_at  = i;
         n_short += int'(short_press);
         n_long  += int'(long_press);
      end
      n_vec++;
      if (long_at !== 5 + LNG || rel_at !== long_at + 1 || n_short !== 0 || n_long !== 1) begin
         n_err++;
         $display("FAIL tie_order got long=%0d rel=%0d short=%0d nlong=%0d expected %0d %0d 0 1",
                  long_at, rel_at, n_short, n_long, 5 + LNG, 6 + LNG);
      end
   endtask

   task automatic test_reset_mid_press();
      int press_at = 0;
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, 1'b0);
         n_vec++;
         if (w_obs !== w_exp) begin
            n_err++;
            $display("FAIL midrst_pre cycle=%0d got=%b expected=%b", i, w_obs, w_exp);
         end
      end
      tick(1'b1, 1'b1);
      n_vec++;
      if (w_obs !== 6'b0 || w_obs !== w_exp) begin
         n_err++;
         $display("FAIL midrst_clear got=%b expected=000000", w_obs);
      end
      for (int i = 1; i <= 10; i++) begin
         tick(1'b1, 1'b0);
         n_vec++;
         if (w_obs !== w_exp) begin
            n_err++;
            $display("FAIL midrst_post edge=%0d got=%b expected=%b", i, w_obs, w_exp);
         end
         if (press_pulse === 1'b1 && press_at == 0) press_at = i;
      end
      n_vec++;
      if (press_at !== 6) begin
         n_err++;
         $display("FAIL midrst_press_latency got=%0d expected=6", press_at);
      end
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 1'b0);
         n_vec++;
         if (w_obs !== w_exp) begin
            n_err++;
            $display("FAIL midrst_release cycle=%0d got=%b expected=%b", i, w_obs, w_exp);
         end
      end
   endtask

   task automatic test_random();
      bit lvl = 1'b0;
      apply_reset();
      for (int seg = 0; seg < 80; seg++) begin
         int len;
         len = int'($urandom_range(1, 24));
         for (int k = 0; k < len; k++) begin
            bit r;
            r = ($urandom_range(0, 149) == 0);
            tick(lvl, r);
            n_vec++;
            if (w_obs !== w_exp) begin
               n_err++;
               $display("FAIL random seg=%0d step=%0d got=%b expected=%b", seg, k, w_obs, w_exp);
            end
         end
         lvl = !lvl;
      end
   endtask

   initial begin
      reset  = 1'b1;
      button = 1'b0;
      model_edge(1'b0, 1'b1);
      test_reset();
      test_glitch();
      test_bounce();
      test_short_press();
      test_long_press();
      test_release_on_long();
      test_reset_mid_press();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
